// File: rtl/aes_kat_pkg.sv
// Shared AES known-answer-test definitions: FSM states, block sizes, and the expected ciphertexts for ECBVarTxt128.
// The expected-ciphertext table is built once at elaboration, so it costs no runtime cycles.
// There is no flow control here; the package only supplies constants and helper functions.
package aes_kat_pkg;

  localparam int NUM_VECTORS_MAX = 128;
  localparam int AES_BLK_W       = 128;
  localparam int ROM_IDX_W       = $clog2(NUM_VECTORS_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  typedef logic [NUM_VECTORS_MAX-1:0][AES_BLK_W-1:0] ct_rom_t;

  // AES S-box in row-major order. Entry 0x00 sits in the top byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte j of a block. Byte 0 is the most significant byte, so the state is laid out column-major.
  function automatic logic [7:0] blk_byte(input logic [127:0] s, input int j);
    return s[127 - 8*j -: 8];
  endfunction

  // Plain AES-128 encryption.
  // The state is built by shifting bytes in, so that no function variable needs a part-select on the left-hand side.
  function automatic logic [127:0] aes128_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, t;
    logic [31:0]  w0, w1, w2, w3, tw;
    logic [7:0]   rcon, a0, a1, a2, a3;
    s    = pt ^ key;
    w0   = key[127:96];
    w1   = key[95:64];
    w2   = key[63:32];
    w3   = key[31:0];
    rcon = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      // SubBytes and ShiftRows: output byte (row r, column c) comes from input column (c+r)%4.
      t = '0;
      for (int j = 0; j < 16; j++)
        t = {t[119:0], sbox(blk_byte(s, 4*(((j/4) + (j%4)) % 4) + (j%4)))};
      s = t;
      if (rnd != 10) begin
        t = '0;
        for (int c = 0; c < 4; c++) begin
          a0 = blk_byte(s, 4*c);
          a1 = blk_byte(s, 4*c + 1);
          a2 = blk_byte(s, 4*c + 2);
          a3 = blk_byte(s, 4*c + 3);
          t  = {t[95:0],
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        s = t;
      end
      tw   = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
      w0   = w0 ^ tw;
      w1   = w1 ^ w0;
      w2   = w2 ^ w1;
      w3   = w3 ^ w2;
      rcon = xtime(rcon);
      s    = s ^ {w0, w1, w2, w3};
    end
    return s;
  endfunction

  // Vector i uses the zero key and a plaintext made of i+1 leading one bits.
  function automatic ct_rom_t build_vartxt128();
    ct_rom_t rom;
    rom = '0;
    for (int i = NUM_VECTORS_MAX - 1; i >= 0; i--)
      rom = {rom[NUM_VECTORS_MAX-2:0], aes128_encrypt(~128'h0 << (127 - i), 128'h0)};
    return rom;
  endfunction

  localparam ct_rom_t VARTXT128_CT = build_vartxt128();

endpackage

// File: rtl/vartxt_expected_rom.sv
// Maps a vector index to its expected ECBVarTxt128 ciphertext, using a constant table.
// Purely combinational, so the index-to-data path has zero cycles of latency.
// There is no handshake; the output follows the index.
module vartxt_expected_rom
  import aes_kat_pkg::*;
(
  input  logic [ROM_IDX_W-1:0] idx,
  output logic [AES_BLK_W-1:0] exp_ct
);

  assign exp_ct = VARTXT128_CT[idx];

endmodule

// File: rtl/vartxt_result_checker.sv
// Checks AES core ciphertexts against the VarTxt128 known answers, counts passes and fails, and latches the first mismatch.
// An accept at one clock edge updates the counters two edges after the cycle in which ct_valid was presented.
// ready stays high for the whole run and there is no backpressure; any ct_valid outside RUN is dropped and flagged as overrun.
module vartxt_result_checker
  import aes_kat_pkg::*;
#(
  parameter int NUM_VECTORS = 128,
  parameter int IDX_W       = 7,
  parameter int CNT_W       = 8
)(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 ct_valid,
  input  logic [127:0]         ciphertext,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 all_pass,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 first_fail_valid,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [127:0]         first_fail_ct,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] SAT_IDX  = CNT_W'(NUM_VECTORS);

  chk_state_e             state, state_nxt;
  logic [CNT_W-1:0]       idx;
  logic                   s1_valid;
  logic [IDX_W-1:0]       s1_idx;
  logic [AES_BLK_W-1:0]   s1_ct;
  logic [AES_BLK_W-1:0]   exp_ct;
  logic [ROM_IDX_W-1:0]   rom_idx;
  logic                   accept, last_accept, enter_run, s2_fail;
  logic [CNT_W-1:0]       fail_cnt_nxt;

  assign ready        = (state == ST_RUN);
  assign busy         = (state == ST_RUN) || (state == ST_DRAIN);
  assign done         = (state == ST_DONE);
  assign accept       = ct_valid && ready;
  assign last_accept  = accept && (idx == LAST_IDX);
  assign enter_run    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign s2_fail      = s1_valid && (s1_ct != exp_ct);
  assign fail_cnt_nxt = s2_fail ? fail_cnt + CNT_ONE : fail_cnt;
  assign rom_idx      = ROM_IDX_W'(s1_idx);

  vartxt_expected_rom u_rom (
    .idx    (rom_idx),
    .exp_ct (exp_ct)
  );

  // Next-state logic. DRAIN lasts exactly one cycle, while the last vector is in stage 2.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (last_accept) state_nxt = ST_DRAIN;
      ST_DRAIN: if (s1_valid) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register. The verdict is registered so that it is valid in the same cycle that done rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      all_pass <= 1'b0;
    end else begin
      state    <= state_nxt;
      all_pass <= (state_nxt == ST_DONE) && (fail_cnt_nxt == '0);
    end
  end

  // Stage 1: capture the accepted block and its index. The index saturates and cannot address past the table.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_ct    <= '0;
      idx      <= '0;
    end else begin
      s1_valid <= accept;
      if (enter_run) begin
        idx <= '0;
      end else if (accept) begin
        s1_ct  <= ciphertext;
        s1_idx <= IDX_W'(idx);
        if (idx != SAT_IDX) idx <= idx + CNT_ONE;
      end
    end
  end

  // Stage 2: compare against the table, bump the counters, and capture the first mismatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_ct    <= '0;
    end else if (enter_run) begin
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_ct    <= '0;
    end else if (s1_valid) begin
      fail_cnt <= fail_cnt_nxt;
      if (!s2_fail) begin
        pass_cnt <= pass_cnt + CNT_ONE;
      end else if (!first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_idx   <= s1_idx;
        first_fail_ct    <= s1_ct;
      end
    end
  end

  // Sticky protocol-error flag for ciphertexts that arrive while the checker is not running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                overrun <= 1'b0;
    else if (enter_run)          overrun <= 1'b0;
    else if (ct_valid && !ready) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_vartxt_result_checker.sv
// Directed bench for vartxt_result_checker. It compares against an independent AES-128 model whose S-box is derived from GF(2^8).
module tb_vartxt_result_checker;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0, ct_valid = 1'b0;
  logic [127:0] ciphertext = '0;
  logic         ready, busy, done, all_pass, first_fail_valid, overrun;
  logic [7:0]   pass_cnt, fail_cnt;
  logic [6:0]   first_fail_idx;
  logic [127:0] first_fail_ct;

  logic         start_b = 1'b0, ct_valid_b = 1'b0;
  logic [127:0] ciphertext_b = '0;
  logic         ready_b, busy_b, done_b, all_pass_b, first_fail_valid_b, overrun_b;
  logic [2:0]   pass_cnt_b, fail_cnt_b;
  logic [1:0]   first_fail_idx_b;
  logic [127:0] first_fail_ct_b;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]   sbt [256];
  logic [31:0]  rk_w [44];
  logic [127:0] exp_ct [128];
  logic [127:0] stim [128];

  always #5 clk = ~clk;

  vartxt_result_checker #(.NUM_VECTORS(128), .IDX_W(7), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ct_valid(ct_valid), .ciphertext(ciphertext),
    .ready(ready), .busy(busy), .done(done), .all_pass(all_pass), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
    .first_fail_ct(first_fail_ct), .overrun(overrun));

  vartxt_result_checker #(.NUM_VECTORS(4), .IDX_W(2), .CNT_W(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .ct_valid(ct_valid_b), .ciphertext(ciphertext_b),
    .ready(ready_b), .busy(busy_b), .done(done_b), .all_pass(all_pass_b), .pass_cnt(pass_cnt_b),
    .fail_cnt(fail_cnt_b), .first_fail_valid(first_fail_valid_b), .first_fail_idx(first_fail_idx_b),
    .first_fail_ct(first_fail_ct_b), .overrun(overrun_b));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv, r, acc;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    r = inv; acc = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      acc = acc ^ r;
    end
    return acc ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] pt);
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int j = 0; j < 16; j++) st[j] = pt[127-8*j -: 8] ^ rk_w[j/4][31-8*(j%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int j = 0; j < 16; j++) tmp[j] = sbt[st[j]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) st[4*c+r] = tmp[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) st[j] = st[j] ^ rk_w[4*rnd + j/4][31-8*(j%4) -: 8];
    end
    o = '0;
    for (int j = 0; j < 16; j++) o = {o[119:0], st[j]};
    return o;
  endfunction

  task automatic init_model();
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 256; i++) sbt[i] = sbox_calc(8'(i));
    for (int i = 0; i < 4; i++) rk_w[i] = 32'h0;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = rk_w[i-1];
      if (i % 4 == 0) begin
        t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      rk_w[i] = rk_w[i-4] ^ t;
    end
    for (int i = 0; i < 128; i++) exp_ct[i] = aes_model(~128'h0 << (127 - i));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; ct_valid = 0; start_b = 0; ct_valid_b = 0;
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  // Drives stim[0..n-1] into the main DUT, with optional random idle gaps. start is raised alongside vector start_at.
  task automatic send_a(input int n, input int max_gap, input int start_at);
    int g;
    for (int i = 0; i < n; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        ct_valid = 0; ciphertext = {4{$urandom()}}; tick();
      end
      ct_valid = 1; ciphertext = stim[i]; start = (i == start_at); tick();
    end
    ct_valid = 0; start = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_model();
    n_chk++; if (exp_ct[0] !== 128'h3ad78e726c1ec02b7ebfe92b23d9ec34)
      $display("FAIL model_vec0: got %h want 3ad78e726c1ec02b7ebfe92b23d9ec34", exp_ct[0]); else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 0; #3;
    n_chk++; if ({ready, busy, done, all_pass, first_fail_valid, overrun} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {ready, busy, done, all_pass, first_fail_valid, overrun}); else n_pass++;
    n_chk++; if ({pass_cnt, fail_cnt, first_fail_idx, first_fail_ct} !== '0)
      $display("FAIL reset_data: got %0d/%0d/%0d/%h want zeros", pass_cnt, fail_cnt, first_fail_idx, first_fail_ct); else n_pass++;
    do_reset();
  endtask

  task automatic test_pass_idx0();
    pulse_start();
    n_chk++; if (ready !== 1'b1) $display("FAIL idx0_ready: got %b want 1", ready); else n_pass++;
    ct_valid = 1; ciphertext = 128'h3ad78e726c1ec02b7ebfe92b23d9ec34; tick();
    ct_valid = 0;
    n_chk++; if (pass_cnt !== 8'd0) $display("FAIL idx0_latency: got %0d want 0", pass_cnt); else n_pass++;
    start = 1; tick(); start = 0;
    n_chk++; if ({pass_cnt, fail_cnt, first_fail_valid} !== {8'd1, 8'd0, 1'b0})
      $display("FAIL idx0_counts: got pass=%0d fail=%0d ffv=%b want 1/0/0", pass_cnt, fail_cnt, first_fail_valid); else n_pass++;
    ct_valid = 1; ciphertext = exp_ct[1]; tick(); ct_valid = 0; tick(); tick();
    n_chk++; if ({pass_cnt, fail_cnt} !== {8'd2, 8'd0})
      $display("FAIL start_in_run_ignored: got pass=%0d fail=%0d want 2/0", pass_cnt, fail_cnt); else n_pass++;
  endtask

  task automatic test_golden();
    do_reset();
    pulse_start();
    for (int i = 0; i < 128; i++) stim[i] = exp_ct[i];
    send_a(128, 0, -1);
    n_chk++; if ({done, busy, ready, pass_cnt} !== {1'b0, 1'b1, 1'b0, 8'd127})
      $display("FAIL golden_drain: got done=%b busy=%b ready=%b pass=%0d want 0/1/0/127", done, busy, ready, pass_cnt); else n_pass++;
    tick();
    n_chk++; if ({done, busy, all_pass, overrun} !== 4'b1010)
      $display("FAIL golden_flags: got done=%b busy=%b all_pass=%b overrun=%b want 1/0/1/0", done, busy, all_pass, overrun); else n_pass++;
    n_chk++; if ({pass_cnt, fail_cnt} !== {8'd128, 8'd0})
      $display("FAIL golden_counts: got pass=%0d fail=%0d want 128/0", pass_cnt, fail_cnt); else n_pass++;
  endtask

  task automatic test_errors();
    pulse_start();
    n_chk++; if ({pass_cnt, done, all_pass, ready} !== {8'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL restart_clear: got pass=%0d done=%b all_pass=%b ready=%b want 0/0/0/1", pass_cnt, done, all_pass, ready); else n_pass++;
    for (int i = 0; i < 128; i++) stim[i] = exp_ct[i];
    stim[5] = exp_ct[5] ^ 128'h1;
    stim[90] = '0;
    send_a(128, 0, -1);
    tick();
    n_chk++; if ({pass_cnt, fail_cnt} !== {8'd126, 8'd2})
      $display("FAIL err_counts: got pass=%0d fail=%0d want 126/2", pass_cnt, fail_cnt); else n_pass++;
    n_chk++; if ({first_fail_valid, first_fail_idx} !== {1'b1, 7'd5})
      $display("FAIL err_first_idx: got ffv=%b idx=%0d want 1/5", first_fail_valid, first_fail_idx); else n_pass++;
    n_chk++; if (first_fail_ct !== stim[5])
      $display("FAIL err_first_ct: got %h want %h", first_fail_ct, stim[5]); else n_pass++;
    n_chk++; if ({done, all_pass} !== 2'b10)
      $display("FAIL err_verdict: got done=%b all_pass=%b want 1/0", done, all_pass); else n_pass++;
  endtask

  task automatic test_gapped();
    pulse_start();
    n_chk++; if ({first_fail_valid, fail_cnt, first_fail_idx} !== '0)
      $display("FAIL restart_ff_clear: got ffv=%b fail=%0d idx=%0d want 0/0/0", first_fail_valid, fail_cnt, first_fail_idx); else n_pass++;
    for (int i = 0; i < 128; i++) stim[i] = exp_ct[i];
    send_a(128, 3, 60);
    n_chk++; if (done !== 1'b0) $display("FAIL gap_drain: got done=%b want 0", done); else n_pass++;
    tick();
    n_chk++; if ({done, all_pass, overrun, pass_cnt, fail_cnt} !== {3'b110, 8'd128, 8'd0})
      $display("FAIL gap_result: got done=%b ap=%b ovr=%b pass=%0d fail=%0d want 1/1/0/128/0",
               done, all_pass, overrun, pass_cnt, fail_cnt); else n_pass++;
    ct_valid = 1; ciphertext = exp_ct[0]; tick(); ct_valid = 0; tick();
    n_chk++; if ({overrun, done, pass_cnt, fail_cnt} !== {2'b11, 8'd128, 8'd0})
      $display("FAIL overrun_after_done: got ovr=%b done=%b pass=%0d fail=%0d want 1/1/128/0",
               overrun, done, pass_cnt, fail_cnt); else n_pass++;
  endtask

  task automatic test_idle_overrun();
    do_reset();
    ct_valid = 1; ciphertext = exp_ct[0]; tick(); ct_valid = 0; tick();
    n_chk++; if ({overrun, busy, pass_cnt, fail_cnt} !== {2'b10, 8'd0, 8'd0})
      $display("FAIL overrun_idle: got ovr=%b busy=%b pass=%0d fail=%0d want 1/0/0/0", overrun, busy, pass_cnt, fail_cnt); else n_pass++;
    pulse_start();
    n_chk++; if ({overrun, ready} !== 2'b01)
      $display("FAIL overrun_clear: got ovr=%b ready=%b want 0/1", overrun, ready); else n_pass++;
  endtask

  task automatic test_midrun_reset();
    do_reset();
    pulse_start();
    for (int i = 0; i < 128; i++) stim[i] = exp_ct[i];
    send_a(40, 0, -1);
    n_chk++; if (pass_cnt !== 8'd39) $display("FAIL mid_pre_reset: got pass=%0d want 39", pass_cnt); else n_pass++;
    #2 reset_n = 0; #1;
    n_chk++; if ({ready, busy, done, all_pass, first_fail_valid, overrun, pass_cnt, fail_cnt, first_fail_idx, first_fail_ct} !== '0)
      $display("FAIL mid_async_reset: got busy=%b pass=%0d fail=%0d want all zero", busy, pass_cnt, fail_cnt); else n_pass++;
    tick(); reset_n = 1; tick(); tick();
    n_chk++; if ({busy, ready, done, pass_cnt, fail_cnt} !== '0)
      $display("FAIL mid_flushed: got busy=%b ready=%b done=%b pass=%0d fail=%0d want 0", busy, ready, done, pass_cnt, fail_cnt); else n_pass++;
    pulse_start();
    send_a(128, 0, -1);
    tick();
    n_chk++; if ({done, all_pass, pass_cnt} !== {2'b11, 8'd128})
      $display("FAIL mid_rerun: got done=%b ap=%b pass=%0d want 1/1/128", done, all_pass, pass_cnt); else n_pass++;
  endtask

  task automatic test_reduced();
    do_reset();
    start_b = 1; tick(); start_b = 0;
    n_chk++; if ({ready_b, busy_b} !== 2'b11) $display("FAIL red_run: got ready=%b busy=%b want 1/1", ready_b, busy_b); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      ct_valid_b = 1; ciphertext_b = exp_ct[i]; tick();
    end
    ct_valid_b = 0;
    n_chk++; if ({done_b, busy_b} !== 2'b01) $display("FAIL red_drain: got done=%b busy=%b want 0/1", done_b, busy_b); else n_pass++;
    tick();
    n_chk++; if ({done_b, all_pass_b, overrun_b, pass_cnt_b, fail_cnt_b} !== {3'b110, 3'd4, 3'd0})
      $display("FAIL red_result: got done=%b ap=%b ovr=%b pass=%0d fail=%0d want 1/1/0/4/0",
               done_b, all_pass_b, overrun_b, pass_cnt_b, fail_cnt_b); else n_pass++;
    n_chk++; if ({first_fail_valid_b, first_fail_idx_b, first_fail_ct_b} !== '0)
      $display("FAIL red_no_fail: got ffv=%b idx=%0d want 0/0", first_fail_valid_b, first_fail_idx_b); else n_pass++;
    ct_valid_b = 1; ciphertext_b = exp_ct[4]; tick(); ct_valid_b = 0; tick();
    n_chk++; if ({overrun_b, done_b, pass_cnt_b} !== {2'b11, 3'd4})
      $display("FAIL red_overrun: got ovr=%b done=%b pass=%0d want 1/1/4", overrun_b, done_b, pass_cnt_b); else n_pass++;
  endtask

  initial begin
    init_model();
    test_model();
    test_reset();
    test_pass_idx0();
    test_golden();
    test_errors();
    test_gapped();
    test_idle_overrun();
    test_midrun_reset();
    test_reduced();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
